// File: rtl/dmem_dma_pkg.sv
// Shared types and constants for the data-memory copy engine.
package dmem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_dma.sv
// Word-copy DMA engine sharing the data memory's single port with the CPU.
// The CPU always wins the port; the engine simply holds its state while cpu_en is high.
module dmem_dma
    import dmem_dma_pkg::*;
#(
    parameter int Nloc  = 64,
    parameter int Dbits = 32,
    localparam int AW   = $clog2(Nloc) + 2,
    localparam int CW   = $clog2(Nloc) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AW-1:0]    src_addr,
    input  logic [AW-1:0]    dst_addr,
    input  logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    input  logic             cpu_en,
    input  logic             cpu_wr,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [Dbits-1:0] cpu_din,
    output logic [Dbits-1:0] cpu_dout,
    output logic             mem_wr,
    output logic [AW-1:0]    mem_addr,
    output logic [Dbits-1:0] mem_din,
    input  logic [Dbits-1:0] mem_dout
);

    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(WORD_BYTES - 1);
    localparam logic [AW-1:0] STEP       = AW'(WORD_BYTES);

    state_t           state;
    logic [AW-1:0]    src_ptr;
    logic [AW-1:0]    dst_ptr;
    logic [CW-1:0]    remaining;
    logic [Dbits-1:0] data_reg;

    // Pointers are AW bits wide, so stepping past the top word wraps to word 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (count != '0) begin
                            src_ptr   <= src_addr & ALIGN_MASK;
                            dst_ptr   <= dst_addr & ALIGN_MASK;
                            remaining <= count;
                            busy      <= 1'b1;
                            state     <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (!cpu_en) begin
                        data_reg <= mem_dout;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (!cpu_en) begin
                        src_ptr   <= src_ptr + STEP;
                        dst_ptr   <= dst_ptr + STEP;
                        remaining <= remaining - CW'(1);
                        if (remaining == CW'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Engine write is gated by reset_n so an abort never commits the pending word.
    always_comb begin
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_din  = data_reg;
        if (cpu_en) begin
            mem_wr   = cpu_wr;
            mem_addr = cpu_addr;
            mem_din  = cpu_din;
        end else begin
            case (state)
                READ:    mem_addr = src_ptr;
                WRITE: begin
                    mem_addr = dst_ptr;
                    mem_wr   = reset_n;
                end
                default: mem_addr = '0;
            endcase
        end
    end

    assign cpu_dout = mem_dout;

endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma: behavioural memory below the DUT plus an array-based reference of memory contents.
module tb_dmem_dma;

    localparam int Nloc  = 64;
    localparam int Dbits = 32;
    localparam int AW    = $clog2(Nloc) + 2;
    localparam int CW    = $clog2(Nloc) + 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic [AW-1:0]    src_addr;
    logic [AW-1:0]    dst_addr;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic             cpu_en;
    logic             cpu_wr;
    logic [AW-1:0]    cpu_addr;
    logic [Dbits-1:0] cpu_din;
    logic [Dbits-1:0] cpu_dout;
    logic             mem_wr;
    logic [AW-1:0]    mem_addr;
    logic [Dbits-1:0] mem_din;
    logic [Dbits-1:0] mem_dout;

    always #5 clock = ~clock;

    dmem_dma #(.Nloc(Nloc), .Dbits(Dbits)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .cpu_en   (cpu_en),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    // Data memory: asynchronous read, synchronous write.
    logic [Dbits-1:0] mem [Nloc];
    assign mem_dout = mem[mem_addr[AW-1:2]];
    always @(posedge clock) begin
        if (mem_wr) mem[mem_addr[AW-1:2]] <= mem_din;
    end

    logic [Dbits-1:0] ref_mem [Nloc];
    int checks = 0;
    int errors = 0;

    bit               cpu_on [256];
    logic             cpu_w  [256];
    logic [AW-1:0]    cpu_a  [256];
    logic [Dbits-1:0] cpu_d  [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_cpu();
        for (int i = 0; i < 256; i++) begin
            cpu_on[i] = 1'b0;
            cpu_w[i]  = 1'b0;
            cpu_a[i]  = '0;
            cpu_d[i]  = '0;
        end
    endtask

    // mode 0: mem[i]=i, 1: random, 2: random with mem[0]=0xA
    task automatic init_mem(input int mode);
        for (int i = 0; i < Nloc; i++) begin
            @(negedge clock);
            if (mode == 0)                  ref_mem[i] = Dbits'(i);
            else if (mode == 2 && i == 0)   ref_mem[i] = 32'hA;
            else                            ref_mem[i] = $urandom;
            cpu_en   = 1'b1;
            cpu_wr   = 1'b1;
            cpu_addr = AW'(i * 4);
            cpu_din  = ref_mem[i];
        end
        @(negedge clock);
        cpu_en = 1'b0;
        cpu_wr = 1'b0;
    endtask

    // Forward word-by-word copy; later reads see earlier writes.
    task automatic ref_copy(input int s, input int d, input int n);
        int sw;
        int dw;
        sw = s / 4;
        dw = d / 4;
        for (int k = 0; k < n; k++)
            ref_mem[(dw + k) % Nloc] = ref_mem[(sw + k) % Nloc];
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < Nloc; i++) chk(tag, mem[i], ref_mem[i]);
    endtask

    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int n, input int rst_cyc, input bit rand_in);
        int exp_done;
        int end_c;
        int start_lim;
        int limit;
        int done_cyc;
        int done_n;
        int busy_err;
        bit wr_seen;
        exp_done = (n == 0) ? 1 : 2 * n + 1;
        if (n != 0)
            for (int c = 1; c < 256; c++)
                if (cpu_on[c] && c < exp_done) exp_done++;
        end_c     = (rst_cyc > 0) ? rst_cyc + 1 : exp_done;
        start_lim = (rst_cyc > 0) ? rst_cyc - 1 : exp_done;
        limit     = exp_done + 4;
        done_cyc  = -1;
        done_n    = 0;
        busy_err  = 0;
        wr_seen   = 1'b0;

        @(negedge clock);
        reset_n  = 1'b1;
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        count    = CW'(n);
        cpu_en   = 1'b0;
        cpu_wr   = 1'b0;
        @(posedge clock);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clock);
            start = (rand_in && c <= start_lim) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rand_in) begin
                src_addr = AW'($urandom);
                dst_addr = AW'($urandom);
                count    = CW'($urandom_range(0, Nloc));
            end
            cpu_en   = cpu_on[c];
            cpu_wr   = cpu_w[c];
            cpu_addr = cpu_a[c];
            cpu_din  = cpu_d[c];
            reset_n  = (c != rst_cyc);
            #1;
            if (c == 1 && n != 0 && !cpu_en && rst_cyc != 1) begin
                chk("read_addr", mem_addr, s & ~AW'(3));
                chk("read_no_wr", mem_wr, 1'b0);
            end
            if (c == 2 && n != 0 && !cpu_en && !cpu_on[1] && rst_cyc > 2) begin
                chk("write_addr", mem_addr, d & ~AW'(3));
                chk("write_wr", mem_wr, 1'b1);
            end
            if (cpu_en && !cpu_wr) chk("cpu_dout", cpu_dout, mem[cpu_addr[AW-1:2]]);
            if (done === 1'b1) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy !== (n != 0 && c < end_c)) busy_err++;
            if (mem_wr === 1'b1 && !cpu_en) wr_seen = 1'b1;
        end
        @(negedge clock);
        start   = 1'b0;
        cpu_en  = 1'b0;
        cpu_wr  = 1'b0;
        reset_n = 1'b1;
        chk("done_cycle", done_cyc, (rst_cyc > 0) ? -1 : exp_done);
        chk("done_pulses", done_n, (rst_cyc > 0) ? 0 : 1);
        chk("busy_pattern", busy_err, 0);
        if (n == 0) chk("no_engine_wr", wr_seen, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int d;
        int n;
        clear_cpu();
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        count    = '0;
        cpu_en   = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = AW'(8'h10);
        cpu_din  = 32'h55;

        // Reset: outputs cleared, CPU path still live.
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cpu_wr", mem_wr, 1'b1);
        chk("rst_cpu_addr", mem_addr, 8'h10);
        chk("rst_cpu_din", mem_din, 32'h55);
        cpu_en = 1'b0;
        #1;
        chk("rst_eng_wr", mem_wr, 1'b0);
        chk("rst_eng_addr", mem_addr, 8'h00);
        chk("rst_eng_din", mem_din, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        cpu_wr  = 1'b0;

        // Basic copy of four words.
        init_mem(0);
        run_copy(8'h00, 8'h80, 4, 0, 1'b0);
        ref_copy(8'h00, 8'h80, 4);
        check_mem("basic_mem");

        // Zero-length copy touches nothing.
        run_copy(8'h10, 8'h20, 0, 0, 1'b0);
        check_mem("zero_mem");

        // CPU steals the port in cycles 2 and 5.
        init_mem(0);
        clear_cpu();
        cpu_on[2] = 1'b1; cpu_w[2] = 1'b1; cpu_a[2] = 8'hF0; cpu_d[2] = 32'hDEAD;
        cpu_on[5] = 1'b1; cpu_w[5] = 1'b1; cpu_a[5] = 8'hF0; cpu_d[5] = 32'hDEAD;
        run_copy(8'h00, 8'h80, 4, 0, 1'b0);
        clear_cpu();
        ref_copy(8'h00, 8'h80, 4);
        ref_mem[60] = 32'hDEAD;
        check_mem("cpu_mem");

        // Source wraps past the top word.
        init_mem(1);
        run_copy(8'hF8, 8'h40, 4, 0, 1'b0);
        ref_copy(8'hF8, 8'h40, 4);
        check_mem("wrap_mem");

        // Overlapping forward copy replicates word 0.
        init_mem(2);
        run_copy(8'h00, 8'h04, 3, 0, 1'b0);
        ref_copy(8'h00, 8'h04, 3);
        check_mem("overlap_mem");

        // Reset in cycle 4 aborts after the first word; a fresh copy then completes.
        init_mem(0);
        run_copy(8'h00, 8'h80, 4, 4, 1'b0);
        ref_copy(8'h00, 8'h80, 1);
        check_mem("abort_mem");
        run_copy(8'h00, 8'h80, 4, 0, 1'b0);
        ref_copy(8'h00, 8'h80, 4);
        check_mem("restart_mem");

        // Random copies with random CPU reads and input noise while busy.
        for (int t = 0; t < 3; t++) begin
            init_mem(1);
            clear_cpu();
            for (int c = 1; c <= 100; c++) begin
                cpu_on[c] = ($urandom_range(0, 3) == 0);
                cpu_a[c]  = AW'($urandom);
            end
            s = $urandom_range(0, 4 * Nloc - 1);
            d = $urandom_range(0, 4 * Nloc - 1);
            n = $urandom_range(0, 40);
            run_copy(AW'(s), AW'(d), n, 0, 1'b1);
            clear_cpu();
            ref_copy(s, d, n);
            check_mem("rand_mem");
        end

        // Idle port: engine drives address 0, CPU reads pass straight through.
        @(negedge clock);
        #1;
        chk("idle_addr", mem_addr, 8'h00);
        chk("idle_wr", mem_wr, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            cpu_en   = 1'b1;
            cpu_wr   = 1'b0;
            cpu_addr = AW'($urandom);
            #1;
            chk("idle_cpu_dout", cpu_dout, ref_mem[cpu_addr[AW-1:2]]);
        end
        @(negedge clock);
        cpu_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_dma.md
# dmem_dma

Word-copy DMA engine and port mux sitting directly upstream of the data memory: it owns the memory's single write/address port and shares it between the CPU and an internal copy engine. Given a source, destination and word count, it copies words inside data memory. It uses the memory's asynchronous read and synchronous write, one read cycle plus one write cycle per word. The CPU always has priority; the engine pauses whenever the CPU uses the port.

## Interface

Parameters:
- Nloc, 64, number of memory words (matches the data memory it drives)
- Dbits, 32, data word width

Ports (AW = $clog2(Nloc)+2, byte address width; CW = $clog2(Nloc)+1):
- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  start a copy; sampled only in IDLE
- src_addr  in  AW  source byte address; bits [1:0] ignored
- dst_addr  in  AW  destination byte address; bits [1:0] ignored
- count  in  CW  words to copy, 0..Nloc
- busy  out  1  high in READ and WRITE states
- done  out  1  one-cycle pulse at copy completion
- cpu_en  in  1  CPU uses memory this cycle (load or store)
- cpu_wr  in  1  CPU store strobe
- cpu_addr  in  AW  CPU byte address
- cpu_din  in  Dbits  CPU store data
- cpu_dout  out  Dbits  equals mem_dout (combinational passthrough)
- mem_wr  out  1  to memory write enable
- mem_addr  out  AW  to memory address
- mem_din  out  Dbits  to memory write data
- mem_dout  in  Dbits  from memory asynchronous read data

## Operation

- Port mux, combinational:
  - When cpu_en=1: mem_addr=cpu_addr, mem_din=cpu_din, mem_wr=cpu_wr.
  - Otherwise the engine drives the port: mem_wr=1 only in WRITE; mem_addr=src_ptr in READ, dst_ptr in WRITE, 0 in IDLE/DONE; mem_din=data_reg.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: start=1 with count≠0 → latch src_ptr={src_addr[AW-1:2],2'b00}, dst_ptr likewise, remaining=count → READ. start=1 with count=0 → DONE (no memory access).
  - READ: cpu_en=0 → data_reg←mem_dout → WRITE. cpu_en=1 → hold state and all registers.
  - WRITE: cpu_en=0 → write committed; src_ptr+=4, dst_ptr+=4, remaining−=1; remaining was 1 → DONE, else → READ. cpu_en=1 → hold, no write.
  - DONE: done=1 → IDLE.
- start is ignored outside IDLE. Inputs are sampled only at the IDLE latch; later changes have no effect.
- Pointer arithmetic is AW bits wide and wraps modulo 4·Nloc. Copying past the top word continues at word 0.
- Overlap: the copy is strictly forward, word by word, and each read sees all earlier writes. dst inside (src, src+4·count) therefore replicates data; this behaviour is required, not an error.
- Reset (reset_n=0 at a posedge): state→IDLE, busy=0, done=0, pointers/remaining/data_reg→0. Reset mid-copy aborts with no done pulse; words already written stay written.
- Engine mem_wr=0 under reset; the CPU path stays live (mem_wr=cpu_en&cpu_wr).

## Timing

- With cpu_en=0 throughout and start sampled at edge 0:
  - word k: READ in cycle 1+2k, WRITE in cycle 2+2k
  - done high in cycle 2N+1; busy high in cycles 1..2N
- count=0: done in cycle 1, busy never asserted.
- Each cpu_en=1 cycle during READ/WRITE delays completion by exactly one cycle.
- Earliest accepted restart: start sampled in the cycle after done (back in IDLE). start coincident with done is ignored.
- cpu_dout and all mem_* outputs are zero-latency combinational paths from their sources.

## Structure

- Package dmem_dma_pkg:
  - state enum (IDLE, READ, WRITE, DONE), 2-bit logic encoding
  - localparam WORD_BYTES=4
- Single module, no sub-modules. The bench instantiates the existing data memory below it with matching Nloc/Dbits.

## Test plan

- Init mem[i]=i; src=0x00, dst=0x80, count=4, cpu_en=0 → mem[32..35]=0..3, done in cycle 9, busy cycles 1..8.
- count=0 → done at cycle 1, mem_wr never 1, memory unchanged.
- Same copy with cpu_en=1 in cycles 2 and 5 (cpu_wr=1 to 0xF0, data 0xDEAD) → mem[60]=0xDEAD, copy correct, done in cycle 11.
- Nloc=64: src=0xF8, dst=0x40, count=4 → reads words 62,63,0,1 into mem[16..19].
- Overlap: mem[0]=0xA, src=0x00, dst=0x04, count=3 → mem[1..3]=0xA.
- reset_n=0 in cycle 4 of a count=4 copy → no done, busy=0 next cycle, only mem[32] written; new start then completes normally.
